// File: rtl/line_xfer_initiator.sv
// -----------------------------------------------------------------------------
// line_xfer_initiator
//
// Requester-side engine for the word-serial memory controller interface.
// It takes whole cache-line read/write requests from the cache/MSHR side.
// Writes are serialised into WORD_SIZE words on mc_wdata. Reads collect
// returned words from mc_rdata back into a line. Each request produces one
// line-wide response.
//
// Parameters
//   WORD_SIZE     width of one word on the controller data bus
//   CL_SIZE_WIDTH cache line width; N = CL_SIZE_WIDTH/WORD_SIZE must be a
//                 power of two and at least 2
//   ADDR_BITCOUNT address width
//   STAT_WIDTH    width of the statistics counters (XFER_STATS_EN only)
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (cache side)
//   req_we                 1 = write line, 0 = read line
//   req_addr, req_wdata    line address and write line
//   rsp_valid/rsp_ready    response handshake (cache side)
//   rsp_we                 echo of the request type
//   rsp_rdata              read line (0 for write responses)
//   mc_ready               controller initialised
//   mc_op                  00 idle, 01 read, 11 write
//   mc_addr                raw address to the controller
//   mc_wdata               write word to the controller
//   mc_rdata, mc_rd_valid  read word from the controller
//   mc_tx_done             transaction-complete pulse
//
// Optional build macro XFER_STATS_EN adds the saturating counters
// stat_rd_cnt, stat_wr_cnt and stat_busy_cnt (STAT_WIDTH bits each).
// -----------------------------------------------------------------------------
module line_xfer_initiator #(
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64,
    parameter int STAT_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_BITCOUNT-1:0] req_addr,
    input  logic [CL_SIZE_WIDTH-1:0] req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_we,
    output logic [CL_SIZE_WIDTH-1:0] rsp_rdata,
    input  logic                     mc_ready,
    output logic [1:0]               mc_op,
    output logic [ADDR_BITCOUNT-1:0] mc_addr,
    output logic [WORD_SIZE-1:0]     mc_wdata,
    input  logic [WORD_SIZE-1:0]     mc_rdata,
    input  logic                     mc_rd_valid,
    input  logic                     mc_tx_done
`ifdef XFER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]    stat_rd_cnt,
    output logic [STAT_WIDTH-1:0]    stat_wr_cnt,
    output logic [STAT_WIDTH-1:0]    stat_busy_cnt
`endif
);

    localparam int N     = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int CNT_W = $clog2(N);

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_ISSUE  = 3'd1,
        WR_STREAM = 3'd2,
        WR_WAIT   = 3'd3,
        RD_WAIT   = 3'd4,
        RESP      = 3'd5
    } state_e;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic [1:0] op_for_state(input state_e s);
        case (s)
            WR_ISSUE, WR_STREAM, WR_WAIT: return OP_WRITE;
            RD_WAIT:                      return OP_READ;
            default:                      return OP_IDLE;
        endcase
    endfunction

    function automatic logic [WORD_SIZE-1:0] line_word(
        input logic [CL_SIZE_WIDTH-1:0] line,
        input logic [CNT_W-1:0]         idx
    );
        return line[int'(idx) * WORD_SIZE +: WORD_SIZE];
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CL_SIZE_WIDTH-1:0]   line_q, line_d;
    logic [ADDR_BITCOUNT-1:0]   addr_q, addr_d;
    logic                       we_q, we_d;
    logic                       idle_q, idle_d;
    logic [1:0]                 mc_op_q, mc_op_d;
    logic [WORD_SIZE-1:0]       mc_wdata_q, mc_wdata_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       accept;

    // idle_q is a registered copy of (state==IDLE) that resets to 0, so
    // req_ready stays low while rst_n is asserted even with mc_ready high,
    // yet still follows mc_ready in the same cycle once idle.
    assign req_ready = idle_q & mc_ready;
    assign accept    = req_ready & req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        addr_d  = addr_q;
        we_d    = we_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d   = req_we;
                    addr_d = req_addr;
                    // A read starts from a zeroed line so words the
                    // controller never returns read back as 0.
                    line_d = req_we ? req_wdata : '0;
                    cnt_d  = '0;
                    state_d = req_we ? WR_ISSUE : RD_WAIT;
                end
            end
            WR_ISSUE: begin
                cnt_d   = '0;
                state_d = WR_STREAM;
            end
            WR_STREAM: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (mc_tx_done) begin
                    state_d = RESP;
                end
            end
            RD_WAIT: begin
                if (mc_rd_valid) begin
                    line_d[int'(cnt_q) * WORD_SIZE +: WORD_SIZE] = mc_rdata;
                    cnt_d = cnt_q + 1'b1;
                end
                // tx_done arrives with the last word, or early on a short
                // transfer; either way the collected line is returned.
                if (mc_tx_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the next state so they register in
        // step with it and never depend combinationally on mc_* inputs.
        mc_op_d     = op_for_state(state_d);
        mc_wdata_d  = (state_d == WR_STREAM) ? line_word(line_d, cnt_d) : '0;
        rsp_valid_d = (state_d == RESP);
        idle_d      = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            idle_q      <= 1'b0;
            mc_op_q     <= OP_IDLE;
            mc_wdata_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            idle_q      <= idle_d;
            mc_op_q     <= mc_op_d;
            mc_wdata_q  <= mc_wdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign mc_op     = mc_op_q;
    assign mc_addr   = addr_q;
    assign mc_wdata  = mc_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = we_q;
    // The line register holds the write data during writes; mask it so a
    // write response carries an all-zero line.
    assign rsp_rdata = we_q ? '0 : line_q;

`ifdef XFER_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating transfer statistics
    // -------------------------------------------------------------------------
    logic [STAT_WIDTH-1:0] stat_rd_q, stat_wr_q, stat_busy_q;
    logic                  rsp_fire;

    assign rsp_fire = (state_q == RESP) & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_q   <= '0;
            stat_wr_q   <= '0;
            stat_busy_q <= '0;
        end else begin
            if (rsp_fire && !we_q) begin
                stat_rd_q <= sat_inc(stat_rd_q);
            end
            if (rsp_fire && we_q) begin
                stat_wr_q <= sat_inc(stat_wr_q);
            end
            if (state_q != IDLE) begin
                stat_busy_q <= sat_inc(stat_busy_q);
            end
        end
    end

    assign stat_rd_cnt   = stat_rd_q;
    assign stat_wr_cnt   = stat_wr_q;
    assign stat_busy_cnt = stat_busy_q;
`endif

endmodule

// File: tb/tb_line_xfer_initiator.sv
// -----------------------------------------------------------------------------
// Testbench for line_xfer_initiator (default parameters, N = 16 words/line).
// A per-cycle vector table covers a write followed back-to-back by a read.
// Hand-written sequences cover response hold, mc_ready gating, short reads,
// asynchronous reset mid-stream and, with XFER_STATS_EN, the counters.
// -----------------------------------------------------------------------------
module tb_line_xfer_initiator;

    localparam int WS = 32;
    localparam int CL = 512;
    localparam int AW = 64;
    localparam int SW = 32;
    localparam int N  = CL / WS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [CL-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_we;
    logic [CL-1:0] rsp_rdata;
    logic          mc_ready;
    logic [1:0]    mc_op;
    logic [AW-1:0] mc_addr;
    logic [WS-1:0] mc_wdata;
    logic [WS-1:0] mc_rdata;
    logic          mc_rd_valid;
    logic          mc_tx_done;
`ifdef XFER_STATS_EN
    logic [SW-1:0] stat_rd_cnt;
    logic [SW-1:0] stat_wr_cnt;
    logic [SW-1:0] stat_busy_cnt;
`endif

    always #5 clk = ~clk;

    line_xfer_initiator #(
        .WORD_SIZE    (WS),
        .CL_SIZE_WIDTH(CL),
        .ADDR_BITCOUNT(AW),
        .STAT_WIDTH   (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_we     (rsp_we),
        .rsp_rdata  (rsp_rdata),
        .mc_ready   (mc_ready),
        .mc_op      (mc_op),
        .mc_addr    (mc_addr),
        .mc_wdata   (mc_wdata),
        .mc_rdata   (mc_rdata),
        .mc_rd_valid(mc_rd_valid),
        .mc_tx_done (mc_tx_done)
`ifdef XFER_STATS_EN
        ,
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_busy_cnt(stat_busy_cnt)
`endif
    );

    typedef struct {
        logic        rv;
        logic        we;
        logic        rdy;
        logic        rdv;
        logic        txd;
        logic        rspr;
        logic [31:0] rdata;
        logic [1:0]  e_op;
        logic        e_rr;
        logic        e_rv;
        logic        e_rwe;
        logic        cw;
        logic [31:0] e_wd;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CL-1:0] mk_line(input logic [31:0] base);
        logic [CL-1:0] l;
        for (int k = 0; k < N; k++) begin
            l[k*WS +: WS] = base + 32'(k);
        end
        return l;
    endfunction

    task automatic drive(input vec_t v);
        req_valid   = v.rv;
        req_we      = v.we;
        mc_ready    = v.rdy;
        mc_rd_valid = v.rdv;
        mc_tx_done  = v.txd;
        rsp_ready   = v.rspr;
        mc_rdata    = v.rdata;
    endtask

    // Waits (bounded) for acceptance of a request already set up by caller.
    task automatic wait_accept(input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            req_valid = 1'b1;
            #1;
            if (req_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk(name, CL'(ok), CL'(1));
    endtask

    task automatic run_write(input logic [AW-1:0] addr, input logic [CL-1:0] line, input int delay);
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = line;
        wait_accept("wr_accept");
        tick();
        req_valid = 1'b0;
        #1;
        chk("wr_issue_op", CL'(mc_op), CL'(2'b11));
        chk("wr_addr", CL'(mc_addr), CL'(addr));
        for (int k = 0; k < N; k++) begin
            tick();
            #1;
            chk($sformatf("wr_word%0d", k), CL'(mc_wdata), CL'(line[k*WS +: WS]));
            chk("wr_stream_op", CL'(mc_op), CL'(2'b11));
        end
        for (int d = 0; d < delay; d++) begin
            tick();
            #1;
            chk("wr_wait_op", CL'(mc_op), CL'(2'b11));
        end
        tick();
        mc_tx_done = 1'b1;
        #1;
        chk("wr_done_op", CL'(mc_op), CL'(2'b11));
        tick();
        mc_tx_done = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        chk("wr_rsp_valid", CL'(rsp_valid), CL'(1'b1));
        chk("wr_rsp_we", CL'(rsp_we), CL'(1'b1));
        chk("wr_rsp_rdata", rsp_rdata, '0);
        chk("wr_rsp_op", CL'(mc_op), CL'(2'b00));
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("wr_rsp_drop", CL'(rsp_valid), CL'(1'b0));
    endtask

    task automatic run_read(input logic [AW-1:0] addr, input logic [CL-1:0] line);
        req_we   = 1'b0;
        req_addr = addr;
        wait_accept("rd_accept");
        for (int k = 0; k < N; k++) begin
            tick();
            req_valid   = 1'b0;
            mc_rd_valid = 1'b1;
            mc_rdata    = line[k*WS +: WS];
            mc_tx_done  = (k == N - 1);
            #1;
            chk("rd_op", CL'(mc_op), CL'(2'b01));
        end
        tick();
        mc_rd_valid = 1'b0;
        mc_tx_done  = 1'b0;
        rsp_ready   = 1'b1;
        #1;
        chk("rd_rsp_valid", CL'(rsp_valid), CL'(1'b1));
        chk("rd_rsp_we", CL'(rsp_we), CL'(1'b0));
        chk("rd_rsp_rdata", rsp_rdata, line);
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("rd_rsp_drop", CL'(rsp_valid), CL'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CL-1:0] exp_line;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 64'h1000;
        req_wdata   = mk_line(32'h1);
        rsp_ready   = 1'b0;
        mc_ready    = 1'b1;
        mc_rdata    = '0;
        mc_rd_valid = 1'b0;
        mc_tx_done  = 1'b0;

        // Per-cycle table: write accepted at cycle 0 (req_valid held high),
        // tx_done at cycle 20, back-to-back read accepted at cycle 22.
        for (int c = 0; c < 40; c++) begin
            vec_t v;
            v = '{default: '0};
            v.rdy = 1'b1;
            if (c <= 21) begin
                v.rv = 1'b1;
                v.we = 1'b1;
            end
            if (c == 0) begin
                v.e_rr = 1'b1;
            end else if (c == 1) begin
                v.e_op = 2'b11;
            end else if (c <= 17) begin
                v.e_op = 2'b11;
                v.cw   = 1'b1;
                v.e_wd = 32'(c - 1);
                if (c == 5) begin
                    // stray read data and tx_done while streaming: ignored
                    v.txd   = 1'b1;
                    v.rdv   = 1'b1;
                    v.rdata = 32'hDEAD_BEEF;
                end
            end else if (c <= 20) begin
                v.e_op = 2'b11;
                v.txd  = (c == 20);
            end else if (c == 21) begin
                v.e_rv  = 1'b1;
                v.e_rwe = 1'b1;
                v.rspr  = 1'b1;
            end else if (c == 22) begin
                v.rv   = 1'b1;
                v.we   = 1'b0;
                v.e_rr = 1'b1;
            end else if (c <= 38) begin
                v.e_op  = 2'b01;
                v.rdv   = 1'b1;
                v.rdata = 32'hA0 + 32'(c - 23);
                v.txd   = (c == 38);
            end else begin
                v.rv    = 1'b1;
                v.we    = 1'b1;
                v.e_rv  = 1'b1;
                v.e_rwe = 1'b0;
            end
            tbl.push_back(v);
        end

        // Reset state (mc_ready high must not leak into req_ready)
        tick();
        #1;
        chk("rst_mc_op", CL'(mc_op), CL'(2'b00));
        chk("rst_mc_addr", CL'(mc_addr), '0);
        chk("rst_mc_wdata", CL'(mc_wdata), '0);
        chk("rst_rsp_valid", CL'(rsp_valid), '0);
        chk("rst_rsp_we", CL'(rsp_we), '0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_req_ready", CL'(req_ready), '0);
        tick();
        tick();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            tick();
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d_op", i), CL'(mc_op), CL'(tbl[i].e_op));
            chk($sformatf("row%0d_req_ready", i), CL'(req_ready), CL'(tbl[i].e_rr));
            chk($sformatf("row%0d_rsp_valid", i), CL'(rsp_valid), CL'(tbl[i].e_rv));
            if (tbl[i].cw) begin
                chk($sformatf("row%0d_wdata", i), CL'(mc_wdata), CL'(tbl[i].e_wd));
            end
            if (tbl[i].e_rv) begin
                chk($sformatf("row%0d_rsp_we", i), CL'(rsp_we), CL'(tbl[i].e_rwe));
            end
        end

        // Response held 5 cycles with a pending request
        exp_line = mk_line(32'hA0);
        for (int i = 0; i < 5; i++) begin
            tick();
            req_valid   = 1'b1;
            req_we      = 1'b1;
            rsp_ready   = 1'b0;
            mc_rd_valid = 1'b0;
            mc_tx_done  = 1'b0;
            #1;
            chk("hold_rsp_valid", CL'(rsp_valid), CL'(1'b1));
            chk("hold_req_ready", CL'(req_ready), CL'(1'b0));
            chk("hold_rdata", rsp_rdata, exp_line);
        end
        chk("rdata_word0", CL'(rsp_rdata[31:0]), CL'(32'hA0));
        chk("rdata_word15", CL'(rsp_rdata[511:480]), CL'(32'hAF));
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("hold_release_valid", CL'(rsp_valid), CL'(1'b1));
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("hold_done_valid", CL'(rsp_valid), CL'(1'b0));
        chk("hold_done_op", CL'(mc_op), CL'(2'b00));

        // mc_ready low for 10 cycles, then a short read (2 words)
        for (int i = 0; i < 10; i++) begin
            tick();
            mc_ready  = 1'b0;
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 64'h2000;
            #1;
            chk("nordy_req_ready", CL'(req_ready), CL'(1'b0));
            chk("nordy_op", CL'(mc_op), CL'(2'b00));
        end
        tick();
        mc_ready = 1'b1;
        #1;
        chk("rdy_rise_accept", CL'(req_ready), CL'(1'b1));
        tick();
        req_valid   = 1'b0;
        mc_ready    = 1'b0;
        mc_rd_valid = 1'b1;
        mc_rdata    = 32'h11;
        #1;
        chk("short_op", CL'(mc_op), CL'(2'b01));
        chk("short_addr", CL'(mc_addr), CL'(64'h2000));
        tick();
        mc_rdata = 32'h22;
        #1;
        chk("short_op2", CL'(mc_op), CL'(2'b01));
        tick();
        mc_rd_valid = 1'b0;
        mc_tx_done  = 1'b1;
        #1;
        chk("short_op3", CL'(mc_op), CL'(2'b01));
        tick();
        mc_tx_done = 1'b0;
        mc_ready   = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        exp_line        = '0;
        exp_line[31:0]  = 32'h11;
        exp_line[63:32] = 32'h22;
        chk("short_rsp_valid", CL'(rsp_valid), CL'(1'b1));
        chk("short_rsp_we", CL'(rsp_we), CL'(1'b0));
        chk("short_rsp_rdata", rsp_rdata, exp_line);
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("short_rsp_drop", CL'(rsp_valid), CL'(1'b0));

        // Asynchronous reset at word 7 of a write stream
        exp_line  = mk_line(32'h100);
        req_we    = 1'b1;
        req_addr  = 64'h3000;
        req_wdata = exp_line;
        wait_accept("rst_wr_accept");
        tick();
        req_valid = 1'b0;
        #1;
        chk("rst_wr_issue", CL'(mc_op), CL'(2'b11));
        for (int k = 0; k < 8; k++) begin
            tick();
            #1;
            chk($sformatf("rst_wr_word%0d", k), CL'(mc_wdata), CL'(exp_line[k*WS +: WS]));
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_op", CL'(mc_op), CL'(2'b00));
        chk("midrst_rsp_valid", CL'(rsp_valid), CL'(1'b0));
        chk("midrst_req_ready", CL'(req_ready), CL'(1'b0));
        chk("midrst_wdata", CL'(mc_wdata), '0);
        chk("midrst_addr", CL'(mc_addr), '0);
`ifdef XFER_STATS_EN
        chk("midrst_stat_wr", CL'(stat_wr_cnt), '0);
        chk("midrst_stat_busy", CL'(stat_busy_cnt), '0);
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // Fresh read after reset, then 3 writes and 1 more read
        run_read(64'h4000, mk_line(32'hB0));
        run_write(64'h5000, mk_line(32'h200), 0);
        run_write(64'h5040, mk_line(32'h300), 1);
        run_write(64'h5080, mk_line(32'h400), 3);
        run_read(64'h6000, mk_line(32'hC0));
`ifdef XFER_STATS_EN
        chk("stat_wr_cnt", CL'(stat_wr_cnt), CL'(32'd3));
        chk("stat_rd_cnt", CL'(stat_rd_cnt), CL'(32'd2));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_xfer_initiator.md
Name: line_xfer_initiator

Overview:
- Requester-side engine for the word-serial memory controller interface.
- Accepts whole cache-line read/write requests from a cache/MSHR and drives the controller's op, address and word data bus.
- Writes: serializes the line into words. Reads: collects returned words into a line.
- Returns one line-wide response per request. Sits between the cache controller and the memory controller.

Parameters:
- WORD_SIZE, 32: width of one word on the common data bus.
- CL_SIZE_WIDTH, 512: cache line width. N = CL_SIZE_WIDTH/WORD_SIZE must be a power of two and at least 2.
- ADDR_BITCOUNT, 64: address width.
- STAT_WIDTH, 32: width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_we  in  1  1 = write line, 0 = read line
- req_addr  in  ADDR_BITCOUNT  line address
- req_wdata  in  CL_SIZE_WIDTH  write line
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_we  out  1  echo of request type
- rsp_rdata  out  CL_SIZE_WIDTH  read line (holds 0 for writes)
- mc_ready  in  1  controller initialised
- mc_op  out  2  00 idle, 01 read, 11 write
- mc_addr  out  ADDR_BITCOUNT  raw address to controller
- mc_wdata  out  WORD_SIZE  write word to controller
- mc_rdata  in  WORD_SIZE  read word from controller
- mc_rd_valid  in  1  mc_rdata valid
- mc_tx_done  in  1  transaction-complete pulse

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=0, rsp_valid=0, rsp_we=0, rsp_rdata=0.
  - mc_op=00, mc_addr=0, mc_wdata=0.
  - Word counter 0, line registers 0.
- All outputs are registered or decoded from registered state only. No combinational path from mc_* inputs to mc_op.
- req_ready = (state==IDLE) && mc_ready. Acceptance latches req_we, req_addr and req_wdata. mc_addr holds the latched address until the return to IDLE.
- States:
  - IDLE: mc_op=00. On acceptance, go to WR_ISSUE if req_we, else RD_WAIT.
  - WR_ISSUE: mc_op=11 for 1 cycle (the controller samples op here). mc_wdata is don't-care. Go to WR_STREAM with counter=0.
  - WR_STREAM: mc_op=11. mc_wdata = line word[counter], word 0 = bits [WORD_SIZE-1:0]. Exactly one word per cycle for N consecutive cycles, no stall. After the cycle with counter==N-1, go to WR_WAIT.
  - WR_WAIT: mc_op=11 held until mc_tx_done is sampled high, then go to RESP.
  - RD_WAIT: mc_op=01 held.
    - Each cycle with mc_rd_valid: store mc_rdata into word[counter], word 0 first, then counter+1.
    - mc_tx_done is sampled together with the last mc_rd_valid. On that cycle, store the word and go to RESP.
  - RESP: mc_op=00 (mandatory; the controller re-samples op the cycle after tx_done). rsp_valid=1, with rsp_we and rsp_rdata stable until rsp_ready. Then go to IDLE.
- Minimum idle gap: mc_op is 00 for at least 2 cycles between transactions (RESP plus IDLE).
- Write occupancy: 1 + N + (cycles until tx_done) + 1 cycle of RESP.
- Counter: log2(N) bits, wraps to 0 naturally after N words. It is cleared on acceptance.
- Boundary conditions:
  - mc_rd_valid outside RD_WAIT: ignored.
  - mc_tx_done outside WR_WAIT/RD_WAIT: ignored.
  - mc_tx_done in RD_WAIT with fewer than N words received: complete anyway. Unreceived words keep their previous value (cleared to 0 at acceptance).
  - mc_ready deasserting mid-transaction: ignored until IDLE.
  - rst_n mid-transaction: immediate return to reset values. The controller is required to share the same reset.

Optional Feature:
- Macro XFER_STATS_EN.
- With the macro defined, add outputs stat_rd_cnt, stat_wr_cnt and stat_busy_cnt, each STAT_WIDTH wide and reset to 0:
  - stat_rd_cnt and stat_wr_cnt increment on each RESP handshake of the corresponding type.
  - stat_busy_cnt increments every cycle the state is not IDLE.
  - All three saturate at all-ones.
- Without the macro: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write, default params (N=16), req_wdata word k = k+1, controller model: accept at T. Required response:
  - mc_op=11 at T+1.
  - mc_wdata=1..16 on T+2..T+17.
  - mc_tx_done at T+20 leads to rsp_valid=1, rsp_we=1, mc_op=00 at T+21.
- Read, model returns word k = 0xA0+k with mc_rd_valid on 16 consecutive cycles and mc_tx_done on the last. Required: rsp_rdata[31:0]=0xA0, rsp_rdata[511:480]=0xAF, rsp_we=0.
- Back-to-back write then read with req_valid held high and rsp_ready=1. Required: mc_op=00 for exactly 2 cycles between transactions; second req_ready pulses only in IDLE.
- mc_ready=0 with req_valid=1 for 10 cycles. Required: req_ready=0 and mc_op=00 throughout; acceptance occurs the cycle mc_ready rises.
- rst_n asserted at word 7 of WR_STREAM. Required: mc_op=00, rsp_valid=0, req_ready=0 the same cycle; after release, a fresh read completes correctly.
- Response held with rsp_ready=0 for 5 cycles. Required: rsp_rdata stable and no new request accepted. With XFER_STATS_EN defined, after 3 writes and 2 reads: stat_wr_cnt=3, stat_rd_cnt=2.
